// File: rtl/lcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_pkg                                                              |
// | HD44780 command bytes, controller states and hex-to-ASCII helper.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package lcd_pkg;

    localparam logic [7:0] CMD_FUNCSET = 8'h38;
    localparam logic [7:0] CMD_DISPON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY   = 8'h06;
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_LINE1   = 8'h80;
    localparam logic [7:0] CMD_LINE2   = 8'hC0;

    typedef enum logic [2:0] {
        ST_POWERUP    = 3'd0,
        ST_INIT       = 3'd1,
        ST_CLEAR_WAIT = 3'd2,
        ST_L1_ADDR    = 3'd3,
        ST_L1_CHAR    = 3'd4,
        ST_L2_ADDR    = 3'd5,
        ST_L2_CHAR    = 3'd6
    } lcd_state_t;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_SETUP = 2'd1,
        PH_PULSE = 2'd2,
        PH_HOLD  = 2'd3
    } wr_phase_t;

    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) return 8'h30 + {4'h0, nib};
        else             return 8'h37 + {4'h0, nib};
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_FUNCSET;
            2'd1:    return CMD_DISPON;
            2'd2:    return CMD_ENTRY;
            default: return CMD_CLEAR;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_byte_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_byte_writer                                                      |
// | One SETUP/PULSE/HOLD E-strobe per byte; RS/D held until next start.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int STEP_CYCLES = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_rs,
    input  logic [7:0] i_byte,
    output logic       o_done,
    output logic       o_lcd_e,
    output logic       o_lcd_rs,
    output logic [7:0] o_lcd_d
);

    localparam int              c_step_w    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [c_step_w-1:0] c_step_last = c_step_w'(STEP_CYCLES - 1);

    wr_phase_t           r_phase, w_phase_nxt;
    logic [c_step_w-1:0] r_step,  w_step_nxt;
    logic                r_e,     w_e_nxt;
    logic                r_rs;
    logic [7:0]          r_d;
    logic                w_step_end;

    assign w_step_end = (r_step == c_step_last);
    assign o_done     = (r_phase == PH_HOLD) && w_step_end;
    assign o_lcd_e    = r_e;
    assign o_lcd_rs   = r_rs;
    assign o_lcd_d    = r_d;

    // A start in the final HOLD cycle restarts SETUP directly, so writes chain with no gap.
    always_comb begin
        w_phase_nxt = r_phase;
        w_step_nxt  = r_step;
        w_e_nxt     = r_e;
        if (i_start) begin
            w_phase_nxt = PH_SETUP;
            w_step_nxt  = '0;
            w_e_nxt     = 1'b0;
        end else if (r_phase != PH_IDLE) begin
            if (w_step_end) begin
                w_step_nxt = '0;
                case (r_phase)
                    PH_SETUP: begin w_phase_nxt = PH_PULSE; w_e_nxt = 1'b1; end
                    PH_PULSE: begin w_phase_nxt = PH_HOLD;  w_e_nxt = 1'b0; end
                    default:  begin w_phase_nxt = PH_IDLE;  w_e_nxt = 1'b0; end
                endcase
            end else begin
                w_step_nxt = r_step + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= PH_IDLE;
            r_step  <= '0;
            r_e     <= 1'b0;
            r_rs    <= 1'b0;
            r_d     <= 8'h00;
        end else begin
            r_phase <= w_phase_nxt;
            r_step  <= w_step_nxt;
            r_e     <= w_e_nxt;
            if (i_start) begin
                r_rs <= i_rs;
                r_d  <= i_byte;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lcd_hex_display.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_hex_display                                                      |
// | Shows lcd_a / lcd_b as 16 hex digits on a 16x2 HD44780 LCD.          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module lcd_hex_display
    import lcd_pkg::*;
#(
    parameter int NBITS_LCD   = 64,
    parameter int STEP_CYCLES = 25,
    parameter int INIT_WAIT   = 750000,
    parameter int CLEAR_WAIT  = 80000
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic [NBITS_LCD-1:0] lcd_a,
    input  logic [NBITS_LCD-1:0] lcd_b,
    output logic                 LCD_E,
    output logic                 LCD_RS,
    output logic                 LCD_RW,
    output logic [7:0]           LCD_D,
    output logic                 init_done,
    output logic                 frame_done
);

    localparam int c_wait_max = (INIT_WAIT > CLEAR_WAIT) ? INIT_WAIT : CLEAR_WAIT;
    localparam int c_cnt_w    = $clog2(c_wait_max + 1);
    localparam logic [c_cnt_w-1:0] c_init_last  = c_cnt_w'(INIT_WAIT - 1);
    localparam logic [c_cnt_w-1:0] c_clear_last = c_cnt_w'(CLEAR_WAIT - 1);

    lcd_state_t           r_state, w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt,   w_cnt_nxt;
    logic [3:0]           r_idx,   w_idx_nxt;
    logic [NBITS_LCD-1:0] r_snap_a, r_snap_b;
    logic                 r_snap_now, r_init_done, r_frame_done;
    logic                 w_start, w_rs, w_wr_done, w_enter_l1;
    logic [7:0]           w_byte, w_char;
    logic [3:0]           w_char_idx;
    logic [NBITS_LCD-1:0] w_word;
    logic [3:0]           w_nibs [16];

    // The address-command states fetch character 0; char states fetch the following one.
    assign w_char_idx = (r_state == ST_L1_ADDR || r_state == ST_L2_ADDR) ? 4'd0 : r_idx + 4'd1;
    assign w_word     = (r_state == ST_L1_ADDR || r_state == ST_L1_CHAR) ? r_snap_a : r_snap_b;

    genvar g;
    generate
        for (g = 0; g < 16; g++) begin : g_nib
            assign w_nibs[g] = w_word[NBITS_LCD-1-4*g -: 4];
        end
    endgenerate

    assign w_char     = hex_to_ascii(w_nibs[w_char_idx]);
    assign w_enter_l1 = (w_state_nxt == ST_L1_ADDR) && (r_state != ST_L1_ADDR);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_start     = 1'b0;
        w_rs        = 1'b0;
        w_byte      = 8'h00;
        case (r_state)
            ST_POWERUP: begin
                if (r_cnt == c_init_last) begin
                    w_start     = 1'b1;
                    w_byte      = CMD_FUNCSET;
                    w_idx_nxt   = 4'd0;
                    w_state_nxt = ST_INIT;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_INIT: begin
                if (w_wr_done) begin
                    if (r_idx == 4'd3) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_CLEAR_WAIT;
                    end else begin
                        w_start   = 1'b1;
                        w_byte    = init_cmd(r_idx[1:0] + 2'd1);
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
            end
            ST_CLEAR_WAIT: begin
                if (r_cnt == c_clear_last) begin
                    w_start     = 1'b1;
                    w_byte      = CMD_LINE1;
                    w_state_nxt = ST_L1_ADDR;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_L1_ADDR, ST_L2_ADDR: begin
                if (w_wr_done) begin
                    w_start     = 1'b1;
                    w_rs        = 1'b1;
                    w_byte      = w_char;
                    w_idx_nxt   = 4'd0;
                    w_state_nxt = (r_state == ST_L1_ADDR) ? ST_L1_CHAR : ST_L2_CHAR;
                end
            end
            ST_L1_CHAR, ST_L2_CHAR: begin
                if (w_wr_done) begin
                    w_start = 1'b1;
                    if (r_idx == 4'd15) begin
                        w_byte      = (r_state == ST_L1_CHAR) ? CMD_LINE2 : CMD_LINE1;
                        w_state_nxt = (r_state == ST_L1_CHAR) ? ST_L2_ADDR : ST_L1_ADDR;
                    end else begin
                        w_rs      = 1'b1;
                        w_byte    = w_char;
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
            end
            default: w_state_nxt = ST_POWERUP;
        endcase
    end

    // Snapshot is taken at the end of the first cycle of the line-1 address write.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_state      <= ST_POWERUP;
            r_cnt        <= '0;
            r_idx        <= 4'd0;
            r_snap_a     <= '0;
            r_snap_b     <= '0;
            r_snap_now   <= 1'b0;
            r_init_done  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_snap_now   <= w_enter_l1;
            r_frame_done <= w_enter_l1 && (r_state == ST_L2_CHAR);
            if (w_enter_l1) r_init_done <= 1'b1;
            if (r_snap_now) begin
                r_snap_a <= lcd_a;
                r_snap_b <= lcd_b;
            end
        end
    end

    lcd_byte_writer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_writer (
        .clk      (clk_2),
        .rst      (reset),
        .i_start  (w_start),
        .i_rs     (w_rs),
        .i_byte   (w_byte),
        .o_done   (w_wr_done),
        .o_lcd_e  (LCD_E),
        .o_lcd_rs (LCD_RS),
        .o_lcd_d  (LCD_D)
    );

    assign LCD_RW     = 1'b0;
    assign init_done  = r_init_done;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
